// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the MiniMIPS32 fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] ZeroWord     = 32'h0000_0000;
  localparam logic            ChipEnable   = 1'b1;
  localparam logic            ChipDisable  = 1'b0;

  typedef enum logic [2:0] {
    FS_BOOT = 3'd0,
    FS_REQ  = 3'd1,
    FS_HOLD = 3'd2,
    FS_DROP = 3'd3,
    FS_ERR  = 3'd4
  } fetch_state_e;

  // One fetched instruction as presented to IF/ID.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            adel;
  } fetch_ent_t;

endpackage

// File: rtl/inst_skid_buf.sv
// Output register plus one-entry skid register between fetch and IF/ID.
module inst_skid_buf
  import fetch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       load_i,
  input  fetch_ent_t load_data_i,
  input  logic       consume_i,
  output logic       out_valid_o,
  output fetch_ent_t out_data_o
);

  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  fetch_ent_t out_q, out_d;
  fetch_ent_t skid_q, skid_d;

  // Pop the output slot (refilling from skid), then place a new entry in the
  // first free slot; data is zeroed whenever a slot is empty.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (clear_i) begin
      out_valid_d  = 1'b0;
      out_d        = '0;
      skid_valid_d = 1'b0;
      skid_d       = '0;
    end else begin
      if (consume_i) begin
        out_valid_d  = skid_valid_q;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
        skid_d       = '0;
      end
      if (load_i) begin
        if (!out_valid_d) begin
          out_valid_d = 1'b1;
          out_d       = load_data_i;
        end else begin
          skid_valid_d = 1'b1;
          skid_d       = load_data_i;
        end
      end
    end
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, memory handshake, redirect handling and output buffering.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  output logic        req_o,
  output logic [31:0] pc_o,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_adel_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic         req_q, req_d;

  logic         buf_clear, buf_load;
  fetch_ent_t   buf_ent, buf_out;
  logic         inst_valid;
  logic         consume, redir, aligned;
  logic [31:0]  redir_pc;

  assign inst_valid = inst_valid_o;
  assign consume    = inst_valid & ~stall_i;
  assign redir      = (flush_i | branch_i) & (state_q != FS_BOOT);
  assign redir_pc   = flush_i ? flush_pc_i : branch_pc_i;
  assign aligned    = (pc_q[1:0] == 2'b00);

  // Next-state, PC, redirect target and buffer controls.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    buf_ent   = '0;
    unique case (state_q)
      FS_BOOT: state_d = FS_REQ;
      FS_REQ: begin
        if (redir) begin
          buf_clear = 1'b1;
          if (req_q && !ack_i) begin
            state_d  = FS_DROP;
            target_d = redir_pc;
          end else begin
            pc_d = redir_pc;
          end
        end else if (!aligned) begin
          if (!inst_valid || consume) begin
            buf_load = 1'b1;
            buf_ent  = '{inst: ZeroWord, pc: pc_q, adel: 1'b1};
            state_d  = FS_ERR;
          end
        end else if (ack_i) begin
          buf_load = 1'b1;
          buf_ent  = '{inst: rdata_i, pc: pc_q, adel: 1'b0};
          pc_d     = pc_q + 32'd4;
          if (inst_valid && !consume) state_d = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (redir) begin
          buf_clear = 1'b1;
          pc_d      = redir_pc;
          state_d   = FS_REQ;
        end else if (consume) begin
          state_d = FS_REQ;
        end
      end
      FS_DROP: begin
        if (redir) begin
          buf_clear = 1'b1;
          if (!ack_i) begin
            target_d = redir_pc;
          end else begin
            pc_d    = redir_pc;
            state_d = FS_REQ;
          end
        end else if (ack_i) begin
          pc_d    = target_q;
          state_d = FS_REQ;
        end
      end
      FS_ERR: begin
        if (redir) begin
          buf_clear = 1'b1;
          pc_d      = redir_pc;
          state_d   = FS_REQ;
        end
      end
      default: state_d = FS_BOOT;
    endcase
    req_d = (((state_d == FS_REQ) && (pc_d[1:0] == 2'b00)) || (state_d == FS_DROP))
            ? ChipEnable : ChipDisable;
  end

  // State, PC, target and request registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FS_BOOT;
      pc_q     <= RESET_PC;
      target_q <= '0;
      req_q    <= ChipDisable;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= req_d;
    end
  end

  inst_skid_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (buf_clear),
    .load_i      (buf_load),
    .load_data_i (buf_ent),
    .consume_i   (consume),
    .out_valid_o (inst_valid_o),
    .out_data_o  (buf_out)
  );

  assign req_o       = req_q;
  assign pc_o        = pc_q;
  assign inst_o      = buf_out.inst;
  assign inst_pc_o   = buf_out.pc;
  assign inst_adel_o = buf_out.adel;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the MiniMIPS32 front end.
- Owns the program counter and drives the IF stage's `addr_i`/`ce_i` pair.
- Runs the request/acknowledge handshake with the instruction memory and presents fetched instructions to IF/ID through a one-entry output register plus a one-entry skid register.
- Applies exception flushes and branch redirects, discarding any wrong-path fetch still in flight.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.

Ports:
- `clk`  in  1  the single clock. Everything samples on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-low.**
- `stall_i`  in  1  IF/ID cannot accept. An instruction is consumed at an edge where `inst_valid_o=1` and `stall_i=0`.
- `flush_i`  in  1  exception or ERET redirect from CP0.
- `flush_pc_i`  in  32  target of the flush.
- `branch_i`  in  1  branch/jump redirect from ID. ID asserts it only after the delay-slot instruction has been consumed.
- `branch_pc_i`  in  32  target of the branch.
- `req_o`  out  1  instruction memory request; feeds IF `ce_i`.
- `pc_o`  out  32  fetch address; feeds IF `addr_i`.
- `ack_i`  in  1  memory returns `rdata_i` this cycle.
- `rdata_i`  in  32  fetched instruction.
- `inst_valid_o`  out  1  output register holds an instruction.
- `inst_o`  out  32  instruction word.
- `inst_pc_o`  out  32  address of `inst_o`.
- `inst_adel_o`  out  1  instruction is a misaligned-fetch bubble.

## Operation
- **Reset** (`rst=0` at an edge, overrides everything):
  - `pc_o=RESET_PC`, `req_o=0`, `inst_valid_o=0`, `inst_o=0`, `inst_pc_o=0`, `inst_adel_o=0`.
  - Skid register empty; state BOOT.
  - `ack_i` is ignored in BOOT, so a request abandoned by reset is dropped.
- **States:** BOOT, REQ, HOLD, DROP, ERR.
- **BOOT:** `req_o=0`. Moves to REQ after one cycle.
- **REQ:** `req_o=1` when `pc_o[1:0]==0`. `pc_o` and `req_o` stay stable until `ack_i`.
  - ack, output register free or consumed this cycle: load output register with {`rdata_i`, `pc_o`}; `pc_o<=pc_o+4` (mod 2^32); stay in REQ.
  - ack, output register full and stalled: load skid register; `pc_o<=pc_o+4`; go to HOLD.
  - Misaligned `pc_o` (`[1:0]!=0`): `req_o=0`, no memory access.
    - Once the output register is free, load it with {`inst_o=0`, `inst_pc_o=pc_o`, `inst_adel_o=1`}.
    - Go to ERR.
- **HOLD:** `req_o=0`. When the output register is consumed, move skid to the output register and return to REQ.
- **ERR:** `req_o=0`. Stays here until a redirect arrives.
- **DROP:** `req_o=1` with the stale `pc_o` held, because a request is never withdrawn before its ack.
  - The redirect target is kept in an internal register.
  - On ack: discard `rdata_i`, set `pc_o<=target`, go to REQ.
- **Redirect** (any state except BOOT):
  - `flush_i` has priority over `branch_i`.
  - Clear the output and skid registers in the same edge, even if stalled.
  - If in REQ or DROP with the request still unacked this cycle: go to DROP and latch the target.
  - Otherwise: `pc_o<=target` and go to REQ. In REQ, an ack arriving in the same cycle is discarded.
  - A redirect arriving while already in DROP overwrites the latched target.

## Timing
- `req_o` and `pc_o` are decoded from registers only, with no combinational path from any input.
- Ack-to-`inst_valid_o` latency is 1 cycle.
- With zero-wait memory (ack in the same cycle as req) and no stall, throughput is 1 instruction per cycle.
- Redirect to first request at the target address:
  - 1 cycle when no request is outstanding.
  - Otherwise the stale ack's cycle plus 1.
- `stall_i` has no effect on `req_o` except through the HOLD state. At most 2 fetched instructions are buffered.
- Instruction order is strictly preserved. No instruction is duplicated or lost without a redirect.

## Structure
- Shared defines file holds:
  - State encodings `FS_BOOT`, `FS_REQ`, `FS_HOLD`, `FS_DROP`, `FS_ERR` (3 bits).
  - `RESET_PC` default.
  - The existing `ZeroWord` and chip-enable constants.
- The output/skid pair is one sub-module, `inst_skid_buf`, with load/consume/clear controls, valid flags and data.
- `fetch_ctrl` keeps the PC register, the redirect-target register and the FSM.

## Test plan
- **Reset and zero-wait stream:** release reset, `ack_i=1` every cycle, no stall.
  - Required: `pc_o` sequence BFC00000, BFC00004, BFC00008.
  - Required: `inst_valid_o` first asserted 1 cycle after the first ack, `inst_pc_o` = BFC00000.
- **Stall with skid:** assert `stall_i` for 4 cycles during streaming.
  - Required: HOLD entered with 2 entries buffered and `req_o=0`.
  - Required: after release, instructions are delivered in order with no gaps or duplicates.
- **Redirect with outstanding request:** 3-cycle memory latency; `branch_i` with target 0x80001000 one cycle after `req_o` rises.
  - Required: stale data discarded, output cleared.
  - Required: next request has `pc_o=80001000`.
- **Simultaneous events:** `flush_i` (target 0xBFC00380) and `branch_i` (target 0x80002000) in the same cycle as `ack_i`.
  - Required: ack data dropped.
  - Required: next `pc_o=BFC00380`.
- **Misaligned target:** branch to 0x80000002.
  - Required: `req_o` stays 0.
  - Required: one bubble with `inst_adel_o=1`, `inst_pc_o=80000002`, `inst_o=0`, then ERR.
  - Required: a flush to 0xBFC00380 resumes fetching.
- **Reset mid-request:** `rst=0` while in DROP, with an `ack_i` arriving on the cycle after reset.
  - Required: all outputs at reset values.
  - Required: ack ignored; first request at BFC00000.
